// File: rtl/spi_pkg.sv
// Shared SPI constants and types for the receiver and the transmitter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default word width, receiver FSM state type, minimum scl half-period.
package spi_pkg;

  // Default bits per word; words travel MSB first.
  localparam int DATA_WIDTH_DEF = 8;

  // Shortest scl high or low phase, in system clocks. The receiver cannot
  // resolve edges closer than this. The transmitter's divider check uses it too.
  localparam int SCL_HALF_MIN = 4;

  // Receiver control states.
  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } rx_state_t;

endpackage

// File: rtl/spi_rx_if.sv
// Groups the SPI serial lines and the receiver's word-output strobes.
// Latency: n/a (wiring only).
// Backpressure: none; the receive side has no ready, and the consumer must take every rx_valid.
// Ports: cs/scl/sda come from the link. rx_data/rx_valid/frame_err/busy go to the consumer.
interface spi_rx_if
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);

  logic                  cs;         // chip select, active-low, async
  logic                  scl;        // serial clock, idle low, async
  logic                  sda;        // serial data, async
  logic [DATA_WIDTH-1:0] rx_data;    // last completed word
  logic                  rx_valid;   // one-cycle pulse on rx_data update
  logic                  frame_err;  // one-cycle pulse on mid-word abort
  logic                  busy;       // high while shifting a frame

  // The link side drives the serial lines and observes the results.
  modport master (
    output cs, scl, sda,
    input  rx_data, rx_valid, frame_err, busy
  );

  // The receiver samples the serial lines and drives the results.
  modport slave (
    input  cs, scl, sda,
    output rx_data, rx_valid, frame_err, busy
  );

endinterface

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous line, with registered edge strobes.
// Latency: sync_o follows d_i after STAGES clocks; rise_o/fall_o come one clock after sync_o changes.
// Backpressure: none; this is a free-running sampler.
// Ports: clk_i, reset_i (sync, active-high), d_i async in; sync_o, rise_o, fall_o out.
module spi_sync #(
  parameter int STAGES = 2  // must be >= 2 for metastability settling
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
      // The strobes are registered, so the consumer sees a detected edge
      // STAGES clocks after the first capture. That gives the documented
      // three-cycle input-to-word latency at the default depth.
      rise_q <= sync_q[STAGES-1] & ~dly_q;
      fall_q <= ~sync_q[STAGES-1] & dly_q;
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_rx.sv
// SPI responder receiver: synchronizes cs/scl/sda, shifts in MSB-first words, and strobes each completed word.
// Latency: rx_data/rx_valid update 3 clocks after the scl rising edge is first captured (SYNC_STAGES=2).
// Backpressure: none; each word is a one-cycle rx_valid pulse, and rx_data is held until the next word.
// Ports: clk, reset (sync, active-high), bus (spi_rx_if.slave: cs/scl/sda in; rx_data/rx_valid/frame_err/busy out).
module spi_rx
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,  // must match the interface's DATA_WIDTH
  parameter int SYNC_STAGES = 2                // minimum 2
) (
  input  logic      clk,
  input  logic      reset,
  spi_rx_if.slave   bus
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic cs_sync, cs_rise, cs_fall_unused;
  logic scl_sync_unused, scl_rise, scl_fall_unused;
  logic sda_sync, sda_rise_unused, sda_fall_unused;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (bus.cs),
    .sync_o  (cs_sync),
    .rise_o  (cs_rise),
    .fall_o  (cs_fall_unused)
  );

  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_scl (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (bus.scl),
    .sync_o  (scl_sync_unused),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall_unused)
  );

  // sda goes through the same depth as scl. The sender holds it for several
  // clocks around the scl rise, so the one-clock gap between sync_o and the
  // registered rise strobe still samples the intended bit.
  spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sda (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (bus.sda),
    .sync_o  (sda_sync),
    .rise_o  (sda_rise_unused),
    .fall_o  (sda_fall_unused)
  );

  rx_state_t             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_HIGH;
      cnt_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      // After reset, cs must first be seen high. If reset is released
      // mid-frame, this keeps us from capturing a misaligned word.
      WAIT_HIGH: begin
        if (cs_sync) state_d = IDLE;
      end

      IDLE: begin
        cnt_d = '0;
        if (!cs_sync) state_d = SHIFT;
      end

      SHIFT: begin
        if (scl_rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sda_sync};
          if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            rx_data_d  = shift_d;
            rx_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // A cs rise ends the frame. If it coincides with the final bit, the
        // word has already completed above and is not an error. Any other
        // partial word, including a bit arriving in the same cycle, is dropped.
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          shift_d = shift_q;
          if (!rx_valid_d && (cnt_q != '0)) frame_err_d = 1'b1;
        end
      end

      default: state_d = WAIT_HIGH;
    endcase

    busy_d = (state_d == SHIFT);
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: a bit-banged SPI sender plus a scoreboard of expected words.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_spi_rx;
  import spi_pkg::*;

  localparam int W = 8;

  logic clk;
  logic reset;

  spi_rx_if #(.DATA_WIDTH(W)) bus ();

  spi_rx #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard plus strobe monitor.
  logic [W-1:0] sb[$];
  int           n_valid   = 0;
  int           n_ferr    = 0;
  logic         busy_seen = 1'b0;
  logic         prev_vld  = 1'b0;
  logic         prev_err  = 1'b0;
  logic [1:0]   st_at_vld = 2'd0;

  always @(negedge clk) begin
    if (bus.busy) busy_seen = 1'b1;
    if (bus.rx_valid || bus.frame_err)
      chk("strobe_rules",
          {29'd0, bus.rx_valid & bus.frame_err, bus.rx_valid & prev_vld, bus.frame_err & prev_err},
          32'd0);
    if (bus.rx_valid) begin
      n_valid++;
      st_at_vld = dut.state_q;
      if (sb.size() == 0) chk("sb_pending", 32'(sb.size()), 32'd1);
      else                chk("rx_data", 32'(bus.rx_data), 32'(sb.pop_front()));
    end
    if (bus.frame_err) n_ferr++;
    prev_vld = bus.rx_valid;
    prev_err = bus.frame_err;
  end

  // Watchdog: the bench always ends on its own.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time budget expired");
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int half);
    bus.sda = b;
    wait_clk(half);
    bus.scl = 1'b1;
    wait_clk(half);
    bus.scl = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] w, input int half, input bit expect_it);
    if (expect_it) sb.push_back(w);
    for (int i = W - 1; i >= 0; i--) send_bit(w[i], half);
  endtask

  task automatic frame_start();
    bus.cs = 1'b0;
    wait_clk(5);
  endtask

  task automatic frame_end();
    wait_clk(4);
    bus.cs = 1'b1;
    wait_clk(6);
  endtask

  int v0, e0;
  logic [W-1:0] tmp;

  initial begin
    reset   = 1'b1;
    bus.cs  = 1'b1;
    bus.scl = 1'b0;
    bus.sda = 1'b0;
    wait_clk(3);
    chk("rst_rx_data",   32'(bus.rx_data), 32'h0);
    chk("rst_rx_valid",  32'(bus.rx_valid), 32'h0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
    chk("rst_busy",      32'(bus.busy), 32'h0);
    chk("rst_state",     32'(dut.state_q), 32'(WAIT_HIGH));
    reset = 1'b0;
    wait_clk(5);
    chk("post_rst_state", 32'(dut.state_q), 32'(IDLE));

    // A single word with a slow scl.
    v0 = n_valid; e0 = n_ferr;
    frame_start();
    chk("t1_busy", 32'(bus.busy), 32'h1);
    send_word(8'b1110_0010, 10, 1'b1);
    frame_end();
    chk("t1_valid_cnt", 32'(n_valid - v0), 32'd1);
    chk("t1_ferr_cnt",  32'(n_ferr - e0), 32'd0);
    chk("t1_busy_end",  32'(bus.busy), 32'h0);

    // Two words in one frame, with busy held across both.
    v0 = n_valid; e0 = n_ferr;
    frame_start();
    send_word(8'hA5, 6, 1'b1);
    chk("t2_busy_mid", 32'(bus.busy), 32'h1);
    send_word(8'h3C, 6, 1'b1);
    chk("t2_busy_end_word", 32'(bus.busy), 32'h1);
    frame_end();
    chk("t2_valid_cnt", 32'(n_valid - v0), 32'd2);
    chk("t2_ferr_cnt",  32'(n_ferr - e0), 32'd0);
    chk("t2_rx_data",   32'(bus.rx_data), 32'h3C);

    // Abort after 5 bits, following a good 0x12.
    frame_start();
    send_word(8'h12, 6, 1'b1);
    frame_end();
    v0 = n_valid; e0 = n_ferr;
    frame_start();
    for (int i = 0; i < 5; i++) send_bit(1'b1, 6);
    wait_clk(2);
    bus.cs = 1'b1;
    wait_clk(6);
    chk("t3_ferr_cnt",  32'(n_ferr - e0), 32'd1);
    chk("t3_valid_cnt", 32'(n_valid - v0), 32'd0);
    chk("t3_rx_data",   32'(bus.rx_data), 32'h12);
    chk("t3_state",     32'(dut.state_q), 32'(IDLE));

    // Reset mid-word, then extra edges with cs still low.
    v0 = n_valid; e0 = n_ferr;
    frame_start();
    for (int i = 0; i < 3; i++) send_bit(1'b1, 6);
    reset = 1'b1;
    wait_clk(2);
    chk("t4_rst_rx_data", 32'(bus.rx_data), 32'h0);
    chk("t4_rst_busy",    32'(bus.busy), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(i[0], 6);
    wait_clk(4);
    chk("t4_state_wait", 32'(dut.state_q), 32'(WAIT_HIGH));
    chk("t4_no_valid",   32'(n_valid - v0), 32'd0);
    chk("t4_no_ferr",    32'(n_ferr - e0), 32'd0);
    bus.cs = 1'b1;
    wait_clk(5);
    frame_start();
    send_word(8'h81, 6, 1'b1);
    frame_end();
    chk("t4_valid_cnt", 32'(n_valid - v0), 32'd1);
    chk("t4_rx_data",   32'(bus.rx_data), 32'h81);

    // scl/sda activity with cs high must do nothing.
    v0 = n_valid; e0 = n_ferr;
    busy_seen = 1'b0;
    tmp = 8'h6B;
    send_word(tmp, 5, 1'b0);
    tmp = ~tmp;
    send_word(tmp, 5, 1'b0);
    wait_clk(4);
    chk("t5_valid_cnt", 32'(n_valid - v0), 32'd0);
    chk("t5_ferr_cnt",  32'(n_ferr - e0), 32'd0);
    chk("t5_busy_seen", 32'(busy_seen), 32'd0);

    // cs rise lands in the same synced cycle as the final scl rise of 0x5A.
    v0 = n_valid; e0 = n_ferr;
    tmp = 8'h5A;
    sb.push_back(tmp);
    frame_start();
    for (int i = W - 1; i >= 1; i--) send_bit(tmp[i], 6);
    bus.sda = tmp[0];
    wait_clk(6);
    bus.scl = 1'b1;
    bus.cs  = 1'b1;
    wait_clk(6);
    bus.scl = 1'b0;
    wait_clk(4);
    chk("t6_valid_cnt",  32'(n_valid - v0), 32'd1);
    chk("t6_ferr_cnt",   32'(n_ferr - e0), 32'd0);
    chk("t6_rx_data",    32'(bus.rx_data), 32'h5A);
    chk("t6_state_next", 32'(st_at_vld), 32'(IDLE));

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
